// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encodings shared by the serial adder files
package serial_adder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: combinational one-bit full adder (x,y,ci) -> (s,co)
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  logic w_p;
  assign w_p = x ^ y;
  assign s   = w_p ^ ci;
  assign co  = (x & y) | (ci & w_p);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first through one full-adder cell
// Ports: clk, rst_n (async active-low); start/in_ready operand handshake with a, b, cin;
// sum, cout (and ovf when SERIAL_ADDER_OVF_EN is defined) qualified by out_valid/out_ready;
// busy high while an operation is in flight or its result is unconsumed.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry, r_cout, r_valid;
  logic             w_s, w_co, w_accept, w_last;
  full_adder_cell u_fa (
    .x (r_a[0]),
    .y (r_b[0]),
    .ci(r_carry),
    .s (w_s),
    .co(w_co)
  );
  assign in_ready  = r_state == ST_IDLE;
  assign busy      = (r_state == ST_SHIFT) || (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign out_valid = r_valid;
  assign w_accept  = start && in_ready;
  assign w_last    = (r_state == ST_SHIFT) && (r_cnt == CW'(WIDTH - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = ST_IDLE;
    w_next = (r_state == ST_IDLE)  ? (start ? ST_SHIFT : ST_IDLE) :
             (r_state == ST_SHIFT) ? (w_last ? ST_DONE : ST_SHIFT) :
             (r_state == ST_DONE)  ? (out_ready ? ST_IDLE : ST_DONE) : ST_IDLE;
  end
  // Sum bits enter at the MSB end so after WIDTH shifts bit 0 sits at sum[0].
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_cnt   <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_a     <= r_a >> 1;
        r_b     <= r_b >> 1;
        r_carry <= w_co;
        r_sum   <= {w_s, r_sum[WIDTH-1:1]};
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_valid <= 1'b1;
        r_cout  <= w_co;
      end else if ((r_state == ST_DONE) && out_ready) r_valid <= 1'b0;
    end
`ifdef SERIAL_ADDER_OVF_EN
  // On the MSB step r_carry is the carry into the MSB and w_co the carry out of it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      ovf <= 1'b0;
    else if (w_last) ovf <= r_carry ^ w_co;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench with a transaction-level reference model
module tb_serial_adder;
  localparam int W = 8;
  logic         clk = 0, rst_n = 0, start = 0, cin = 0, out_ready = 0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, cout, out_valid, busy;
  logic [W-1:0] sum;
  int           n_chk = 0, n_fail = 0;
  logic         m_idle, m_valid, m_cout;
  logic [W-1:0] m_sum;
  logic [W:0]   m_res;
  int           m_edges;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf, m_ovf, m_ovf_p;
`endif
  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: accept captures a+b+cin; result appears WIDTH+1 edges after accept.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_idle <= 1; m_valid <= 0; m_sum <= '0; m_cout <= 0; m_edges <= 0; m_res <= '0;
`ifdef SERIAL_ADDER_OVF_EN
      m_ovf <= 0; m_ovf_p <= 0;
`endif
    end else if (m_idle) begin
      if (start) begin
        m_idle  <= 0;
        m_edges <= 1;
        m_res   <= (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
`ifdef SERIAL_ADDER_OVF_EN
        m_ovf_p <= (a[W-1] == b[W-1]) && (((a + b + W'(cin)) >> (W-1)) != W'(a[W-1]));
`endif
      end
    end else if (!m_valid) begin
      m_edges <= m_edges + 1;
      if (m_edges == W) begin
        m_valid <= 1;
        m_sum   <= m_res[W-1:0];
        m_cout  <= m_res[W];
`ifdef SERIAL_ADDER_OVF_EN
        m_ovf   <= m_ovf_p;
`endif
      end
    end else if (out_ready) begin
      m_valid <= 0;
      m_idle  <= 1;
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("in_ready", in_ready, m_idle);
      chk("busy", busy, !m_idle);
      chk("out_valid", out_valid, m_valid);
      if (m_idle || m_valid) begin
        chk("sum", sum, m_sum);
        chk("cout", cout, m_cout);
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", ovf, m_ovf);
`endif
      end
    end
  task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                     input logic [W-1:0] es, input logic ec, input int hold, input bit glitch);
    int n;
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1; out_ready = 0;
    @(negedge clk);
    start = 0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (glitch && n == 3) begin start = 1; a = 8'hAA; b = 8'h55; cin = 1; out_ready = 1; end
      if (glitch && n == 4) begin start = 0; out_ready = 0; end
    end
    chk("latency", n, W + 1);
    chk("lit_sum", sum, es);
    chk("lit_cout", cout, ec);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_sum", sum, es);
      chk("hold_cout", cout, ec);
      chk("hold_valid", out_valid, 1);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("post_in_ready", in_ready, 1);
    chk("post_valid", out_valid, 0);
    chk("post_sum", sum, es);
  endtask
  initial begin
    #12 rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_busy", busy, 0);
    txn(8'h0F, 8'h01, 0, 8'h10, 0, 0, 0);
    txn(8'hFF, 8'h01, 0, 8'h00, 1, 0, 0);
    txn(8'h00, 8'h00, 1, 8'h01, 0, 0, 0);
    txn(8'h5A, 8'h3C, 1, 8'h97, 0, 20, 0);
    txn(8'h21, 8'h43, 0, 8'h64, 0, 0, 1);
    txn(8'h80, 8'h80, 1, 8'h01, 1, 2, 0);
    txn(8'hFF, 8'hFF, 1, 8'hFF, 1, 0, 0);
    @(negedge clk);
    a = 8'hC3; b = 8'h11; start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    #3 rst_n = 0;
    #1;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1;
    txn(8'h12, 8'h34, 0, 8'h46, 0, 0, 0);
`ifdef SERIAL_ADDER_OVF_EN
    txn(8'h7F, 8'h01, 0, 8'h80, 0, 0, 0);
    chk("lit_ovf_7f", ovf, 1);
    txn(8'hFF, 8'h01, 0, 8'h00, 1, 0, 0);
    chk("lit_ovf_ff", ovf, 0);
`endif
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
